// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: condition codes,
// micro-op kinds, pipeline entry layouts and the branch condition decoder.
package branch_pkg;

  localparam int XLEN = 32;

  // Conditional branch encodings carried on funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Micro-op kinds; 2'b11 is reserved and resolves as not-taken
  localparam logic [1:0] OPK_BR   = 2'b00;
  localparam logic [1:0] OPK_JAL  = 2'b01;
  localparam logic [1:0] OPK_JALR = 2'b10;
  localparam logic [1:0] OPK_RSV  = 2'b11;

  // Return address step for JAL/JALR
  localparam logic [XLEN-1:0] LINK_STEP = 32'd4;

  // S1 holds the raw captured micro-op
  typedef struct packed {
    logic            valid;
    logic [1:0]      op_kind;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } s1_entry_t;

  // S2 holds the resolved decision presented to the consumer
  typedef struct packed {
    logic            valid;
    logic            taken;
    logic            misalign;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
  } s2_entry_t;

  localparam s1_entry_t S1_EMPTY = {$bits(s1_entry_t){1'b0}};
  localparam s2_entry_t S2_EMPTY = {$bits(s2_entry_t){1'b0}};

  // Map a funct3 condition onto the compare flags; illegal codes never branch
  function automatic logic cond_taken(input logic [2:0] f3,
                                      input logic       eq,
                                      input logic       lt,
                                      input logic       ltu);
    logic t;
    case (f3)
      F3_BEQ:  t = eq;
      F3_BNE:  t = ~eq;
      F3_BLT:  t = lt;
      F3_BGE:  t = ~lt;
      F3_BLTU: t = ltu;
      F3_BGEU: t = ~ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Subtract-and-flags comparator: one XLEN+1 bit subtraction yields
// equality, unsigned less-than (borrow) and signed less-than.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         lt,
  output logic         ltu
);

  logic [W:0] diff_s;

  // a - b as a + ~b + 1; the top bit is the carry out (no borrow)
  always_comb begin
    diff_s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  end

  // Derive flags; on sign mismatch the sign of a decides, so overflow
  // in the subtraction can never corrupt the signed result
  always_comb begin
    eq  = (diff_s[W-1:0] == {W{1'b0}});
    ltu = ~diff_s[W];
    if (a[W-1] != b[W-1]) begin
      lt = a[W-1];
    end else begin
      lt = diff_s[W-1];
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: S1 captures the micro-op, S2 holds the
// resolved taken/target/link decision. A taken, aligned result flushes
// the younger S1 entry and anything accepted in the same cycle.
module branch_resolve_unit
  import branch_pkg::*;
(
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] Rs1,
  input  logic [XLEN-1:0] Rs2,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] Imm,
  input  logic [2:0]      funct3,
  input  logic [1:0]      op_kind,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] link,
  output logic            misalign,
  output logic            flush
);

  s1_entry_t       s1_r;
  s2_entry_t       s2_r;
  s2_entry_t       s2_next_s;

  logic            eq_s;
  logic            lt_s;
  logic            ltu_s;
  logic            taken_s;
  logic [XLEN-1:0] pc_tgt_s;
  logic [XLEN-1:0] reg_tgt_s;
  logic [XLEN-1:0] target_s;
  logic            fire_s;
  logic            flush_s;
  logic            s1_adv_s;
  logic            accept_s;

  branch_cmp #(.W(XLEN)) u_cmp (
    .a   (s1_r.rs1),
    .b   (s1_r.rs2),
    .eq  (eq_s),
    .lt  (lt_s),
    .ltu (ltu_s)
  );

  // Handshake and kill control
  always_comb begin
    fire_s   = s2_r.valid & out_ready;
    flush_s  = fire_s & s2_r.taken & ~s2_r.misalign;
    s1_adv_s = ~s2_r.valid | out_ready;
    in_ready = ~s1_r.valid | s1_adv_s;
    accept_s = in_valid & in_ready;
  end

  // Resolve the S1 micro-op into the next S2 contents
  always_comb begin
    pc_tgt_s  = s1_r.pc + s1_r.imm;
    reg_tgt_s = s1_r.rs1 + s1_r.imm;
    case (s1_r.op_kind)
      OPK_BR: begin
        taken_s  = cond_taken(s1_r.funct3, eq_s, lt_s, ltu_s);
        target_s = pc_tgt_s;
      end
      OPK_JAL: begin
        taken_s  = 1'b1;
        target_s = pc_tgt_s;
      end
      OPK_JALR: begin
        taken_s  = 1'b1;
        target_s = {reg_tgt_s[XLEN-1:1], 1'b0};
      end
      default: begin
        taken_s  = 1'b0;
        target_s = pc_tgt_s;
      end
    endcase
    s2_next_s = S2_EMPTY;
    if (s1_r.valid) begin
      s2_next_s.valid    = 1'b1;
      s2_next_s.taken    = taken_s;
      s2_next_s.misalign = taken_s & target_s[1];
      s2_next_s.target   = target_s;
      s2_next_s.link     = s1_r.pc + LINK_STEP;
    end else begin
      s2_next_s = S2_EMPTY;
    end
  end

  // S1 register: capture on accept, drop on flush, empty when it advances
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      s1_r <= S1_EMPTY;
    end else if (flush_s) begin
      s1_r <= S1_EMPTY;
    end else if (accept_s) begin
      s1_r <= '{valid: 1'b1, op_kind: op_kind, funct3: funct3,
                rs1: Rs1, rs2: Rs2, pc: PC, imm: Imm};
    end else if (s1_adv_s) begin
      s1_r.valid <= 1'b0;
    end else begin
      s1_r <= s1_r;
    end
  end

  // S2 register: load resolved result when S1 advances, hold under stall
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      s2_r <= S2_EMPTY;
    end else if (flush_s) begin
      s2_r <= S2_EMPTY;
    end else if (s1_adv_s) begin
      s2_r <= s2_next_s;
    end else begin
      s2_r <= s2_r;
    end
  end

  // Present S2 to the consumer
  always_comb begin
    out_valid = s2_r.valid;
    taken     = s2_r.taken;
    target    = s2_r.target;
    link      = s2_r.link;
    misalign  = s2_r.misalign;
    flush     = flush_s;
  end

endmodule
